// File: rtl/ai_accel_pkg.sv
// Shared constants and types for the AI accelerator slave port and its Wishbone arbiter.
package ai_accel_pkg;

    localparam logic [31:0] OP_GO_ADDR = 32'h0000_0005;
    localparam logic [31:0] GO_VALUE   = 32'hFFFF_FFFF;
    localparam logic [31:0] GO_RELEASE = 32'h0000_0000;

    // Top address bits select the accelerator region: op registers, then matrices A, B, C.
    localparam logic [1:0] PFX_OP = 2'b00;
    localparam logic [1:0] PFX_A  = 2'b01;
    localparam logic [1:0] PFX_B  = 2'b10;
    localparam logic [1:0] PFX_C  = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RECOVER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ai_arb_rr2.sv
// Combinational two-way round-robin picker; a held lock restricts eligibility to the owner.
module ai_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock,
    input  logic       owner,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic [1:0] elig;

    always_comb begin
        elig = req;
        if (lock) begin
            elig = req & (owner ? 2'b10 : 2'b01);
        end
        gnt_valid = |elig;
        gnt_idx   = 1'b0;
        case (elig)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ai_accel_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with GO-ownership lock in front of the accelerator slave.
// Define AI_ARB_TIMEOUT_EN to build the BUSY timeout that ends a stuck cycle with an error pulse.
module ai_accel_wb_arbiter
    import ai_accel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_data_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_data_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [31:0] s_data_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_data_i
);

    arb_state_e state;
    logic       gnt_q;
    logic       last_grant;
    logic       lock;
    logic       owner;
    logic       pick_valid;
    logic       pick_idx;
    logic       busy;
    logic       go_write;
    logic       timeout_hit;

    ai_arb_rr2 u_rr2 (
        .req        ({m1_stb_i, m0_stb_i}),
        .last_grant (last_grant),
        .lock       (lock),
        .owner      (owner),
        .gnt_valid  (pick_valid),
        .gnt_idx    (pick_idx)
    );

    assign busy     = (state == ARB_BUSY);
    assign go_write = s_we_o && (s_addr_o == OP_GO_ADDR);

    // A master that illegally dropped its strobe mid-cycle gets neither ack nor data.
    assign m0_ack_o  = busy && !gnt_q && m0_stb_i && s_ack_i;
    assign m1_ack_o  = busy &&  gnt_q && m1_stb_i && s_ack_i;
    assign m0_data_o = (busy && !gnt_q && m0_stb_i) ? s_data_i : '0;
    assign m1_data_o = (busy &&  gnt_q && m1_stb_i) ? s_data_i : '0;

`ifdef AI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (state == ARB_IDLE && pick_valid) begin
            to_cnt <= '0;
        end else if (busy) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle so the error lands where an ack would.
    assign timeout_hit = busy && !s_ack_i && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign m0_err_o    = timeout_hit && !gnt_q;
    assign m1_err_o    = timeout_hit &&  gnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign m0_err_o       = 1'b0;
    assign m1_err_o       = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ARB_IDLE;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            lock       <= 1'b0;
            owner      <= 1'b0;
            s_addr_o   <= '0;
            s_we_o     <= 1'b0;
            s_data_o   <= '0;
            s_stb_o    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_idx;
                        last_grant <= pick_idx;
                        s_addr_o   <= pick_idx ? m1_addr_i : m0_addr_i;
                        s_we_o     <= pick_idx ? m1_we_i   : m0_we_i;
                        s_data_o   <= pick_idx ? m1_data_i : m0_data_i;
                        s_stb_o    <= 1'b1;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (s_ack_i) begin
                        s_stb_o <= 1'b0;
                        state   <= ARB_RECOVER;
                        if (go_write && s_data_o == GO_VALUE) begin
                            lock  <= 1'b1;
                            owner <= gnt_q;
                        end else if (go_write && s_data_o == GO_RELEASE && owner == gnt_q) begin
                            lock  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        s_stb_o <= 1'b0;
                        state   <= ARB_RECOVER;
                    end
                end
                ARB_RECOVER: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ai_accel_wb_arbiter.sv
// Randomized bench for ai_accel_wb_arbiter against a transaction-level reference model.
module tb_ai_accel_wb_arbiter;
    import ai_accel_pkg::*;

    localparam int unsigned TO_CYC = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_we    [2];
    logic        m_stb   [2];
    logic        m_ack   [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];
    logic [31:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;
    logic        s_we_o;
    logic        s_stb_o;
    logic        s_ack_i;

    ai_accel_wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .m0_addr_i (m_addr[0]),
        .m0_we_i   (m_we[0]),
        .m0_data_i (m_wdata[0]),
        .m0_stb_i  (m_stb[0]),
        .m0_ack_o  (m_ack[0]),
        .m0_err_o  (m_err[0]),
        .m0_data_o (m_rdata[0]),
        .m1_addr_i (m_addr[1]),
        .m1_we_i   (m_we[1]),
        .m1_data_i (m_wdata[1]),
        .m1_stb_i  (m_stb[1]),
        .m1_ack_o  (m_ack[1]),
        .m1_err_o  (m_err[1]),
        .m1_data_o (m_rdata[1]),
        .s_addr_o  (s_addr_o),
        .s_we_o    (s_we_o),
        .s_data_o  (s_data_o),
        .s_stb_o   (s_stb_o),
        .s_ack_i   (s_ack_i),
        .s_data_i  (s_data_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: who owns the slave, idle gap after an ack, fairness and lock bookkeeping.
    int          cur;
    int          cool;
    int          last_g;
    int          own;
    bit          lk;
    bit          active [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    logic        r_we   [2];
    int          stb_age;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        cur = -1; cool = 0; last_g = 1; own = 0; lk = 1'b0; stb_age = 0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
        r_addr[i] = a; r_we[i] = w; r_data[i] = d; active[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        logic [31:0] a;
        logic [31:0] d;
        case ($urandom_range(0, 3))
            0:       a = OP_GO_ADDR;
            1:       a = 32'h0;
            2:       a = 32'h1;
            default: a = $urandom;
        endcase
        d = $urandom;
        if (a == OP_GO_ADDR) d = ($urandom_range(0, 1) == 0) ? GO_VALUE : GO_RELEASE;
        set_req(i, a, 1'($urandom_range(0, 1)), d);
    endtask

    task automatic model_step();
        bit e0;
        bit e1;
        chk("s_stb", 32'(s_stb_o), 32'(cur >= 0));
        if (cur >= 0) begin
            chk("s_addr", s_addr_o, r_addr[cur]);
            chk("s_we", 32'(s_we_o), 32'(r_we[cur]));
            chk("s_data", s_data_o, r_data[cur]);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ack", i), 32'(m_ack[i]), 32'(cur == i && s_ack_i));
            chk($sformatf("m%0d_data", i), m_rdata[i], (cur == i) ? s_data_i : 32'h0);
            chk($sformatf("m%0d_err", i), 32'(m_err[i]), 32'h0);
        end
        if (cur >= 0) begin
            if (s_ack_i) begin
                if (r_we[cur] && r_addr[cur] == OP_GO_ADDR) begin
                    if (r_data[cur] == GO_VALUE) begin
                        lk = 1'b1; own = cur;
                    end else if (r_data[cur] == GO_RELEASE && lk && own == cur) begin
                        lk = 1'b0;
                    end
                end
                active[cur] = 1'b0;
                cur  = -1;
                cool = 1;
            end
        end else if (cool > 0) begin
            cool--;
        end else begin
            e0 = m_stb[0] && (!lk || own == 0);
            e1 = m_stb[1] && (!lk || own == 1);
            if (e0 && e1) cur = (last_g == 0) ? 1 : 0;
            else if (e0) cur = 0;
            else if (e1) cur = 1;
            if (cur >= 0) last_g = cur;
        end
    endtask

    // req_mode: 0 manual, 1 random, 2 back-to-back reads of 0; ack_mode: 0 never, 1 random, 2 at once.
    task automatic tick(input int req_mode, input int ack_mode);
        @(posedge wb_clk_i); #1;
        for (int i = 0; i < 2; i++) begin
            if (!active[i]) begin
                if (req_mode == 1 && $urandom_range(0, 2) != 0) rand_req(i);
                else if (req_mode == 2) set_req(i, 32'h0, 1'b0, 32'h0);
            end
            m_stb[i]   = active[i];
            m_addr[i]  = r_addr[i];
            m_we[i]    = r_we[i];
            m_wdata[i] = r_data[i];
        end
        stb_age = s_stb_o ? stb_age + 1 : 0;
        case (ack_mode)
            0:       s_ack_i = 1'b0;
            1:       s_ack_i = s_stb_o && ($urandom_range(0, 2) == 0 || stb_age >= 8);
            default: s_ack_i = s_stb_o;
        endcase
        s_data_i = $urandom;
        @(negedge wb_clk_i);
        model_step();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((active[0] || active[1]) && n < 40) begin
            tick(0, 2);
            n++;
        end
        chk(tag, 32'(active[0] || active[1]), 32'h0);
    endtask

    task automatic do_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        m_stb[0] = 1'b0; m_stb[1] = 1'b0; s_ack_i = 1'b0;
        active[0] = 1'b0; active[1] = 1'b0;
        model_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
    endtask

    initial begin
        int first;
        int n;
        wb_rst_i = 1'b1;
        s_ack_i  = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            m_stb[i] = 1'b0; m_addr[i] = '0; m_we[i] = 1'b0; m_wdata[i] = '0;
            r_addr[i] = '0; r_we[i] = 1'b0; r_data[i] = '0; active[i] = 1'b0;
        end
        model_reset();
        #2;
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_m0_ack", 32'(m_ack[0]), 32'h0);
        chk("rst_m1_data", m_rdata[1], 32'h0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        s_ack_i  = 1'b0;

        // Single write from m0.
        set_req(0, 32'h1, 1'b1, 32'd8);
        repeat (5) tick(0, 2);
        drain("single_done");

        // Both masters saturating with reads.
        repeat (24) tick(2, 2);
        drain("alt_drain");

        // Lock hand-off between masters.
        do_reset();
        set_req(0, OP_GO_ADDR, 1'b1, GO_VALUE);
        drain("go_set_done");
        set_req(1, 32'h0, 1'b0, 32'h0);
        repeat (8) tick(0, 2);
        chk("lock_stall_stb", 32'(s_stb_o), 32'h0);
        set_req(0, OP_GO_ADDR, 1'b1, GO_RELEASE);
        drain("lock_release");

        // Random traffic.
        do_reset();
        repeat (1500) tick(1, 1);

        // Asynchronous reset in the middle of a locked, unacknowledged cycle.
        do_reset();
        set_req(1, OP_GO_ADDR, 1'b1, GO_VALUE);
        drain("m1_go");
        set_req(0, 32'h0, 1'b0, 32'h0);
        set_req(1, 32'h1, 1'b0, 32'h0);
        repeat (4) tick(0, 0);
        chk("pre_rst_stb", 32'(s_stb_o), 32'h1);
        chk("pre_rst_addr", s_addr_o, 32'h1);
        @(posedge wb_clk_i); #3;
        s_ack_i  = 1'b1;
        s_data_i = 32'hA5A5_5A5A;
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("mid_rst_s_addr", s_addr_o, 32'h0);
        chk("mid_rst_s_we", 32'(s_we_o), 32'h0);
        chk("mid_rst_s_data", s_data_o, 32'h0);
        chk("mid_rst_m1_ack", 32'(m_ack[1]), 32'h0);
        chk("mid_rst_m1_data", m_rdata[1], 32'h0);
        chk("mid_rst_m0_err", 32'(m_err[0]), 32'h0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        s_ack_i  = 1'b0;
        m_stb[0] = 1'b0; m_stb[1] = 1'b0;
        model_reset();
        first = -1;
        n = 0;
        while (first < 0 && n < 20) begin
            tick(0, 2);
            if (m_ack[0] === 1'b1) first = 0;
            else if (m_ack[1] === 1'b1) first = 1;
            n++;
        end
        chk("post_rst_tie", 32'(first), 32'h0);
        drain("post_rst_drain");

`ifdef AI_ARB_TIMEOUT_EN
        // Slave never answers: error in BUSY cycle TO_CYC, next grant visible three cycles later.
        do_reset();
        m_addr[0] = 32'h0; m_we[0] = 1'b0; m_stb[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge wb_clk_i);
            chk($sformatf("to_stb_c%0d", k), 32'(s_stb_o),
                32'((k >= 1 && k <= int'(TO_CYC)) || k == int'(TO_CYC) + 3));
            chk($sformatf("to_err_c%0d", k), 32'(m_err[0]), 32'(k == int'(TO_CYC)));
            chk($sformatf("to_ack_c%0d", k), 32'(m_ack[0]), 32'h0);
            if (k == int'(TO_CYC) + 3) chk("to_next_addr", s_addr_o, 32'h1);
            @(posedge wb_clk_i); #1;
            if (k == int'(TO_CYC)) begin
                m_stb[0] = 1'b0;
                m_addr[1] = 32'h1; m_we[1] = 1'b0; m_stb[1] = 1'b1;
            end
        end
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
